// File: rtl/des_core.sv
// Iterative single-DES engine: one Feistel round per clock over a captured 64-bit block and 56-bit key.
// Latency 17 cycles from the start edge to the done edge; one block per 17 cycles when starts are back to back.
// A start is accepted when idle or on the final edge; starts while rounds are running are ignored.
module des_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        s,
  input  logic        e,
  input  logic [55:0] k,
  input  logic [63:0] in,
  output logic [63:0] out,
  output logic        done,
  output logic        busy
);

  // DES bit numbering: bit 1 is the MSB of each vector.
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [0:47] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // S1..S8, 64 entries each, indexed row*16 + column.
  localparam int SBOX_T [0:511] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_t;

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
    return r;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
    return r;
  endfunction

  // Reinsert zero parity bits (never selected by PC-1) and apply PC-1.
  function automatic logic [55:0] pc1_perm(input logic [55:0] key);
    logic [63:0] k64;
    logic [55:0] r;
    k64 = '0;
    r   = '0;
    for (int i = 0; i < 8; i++) k64[63-8*i -: 8] = {key[55-7*i -: 7], 1'b0};
    for (int i = 0; i < 56; i++) r[55-i] = k64[64-PC1_T[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
    return r;
  endfunction

  // f(R, K) = P(S(E(R) xor K))
  function automatic logic [31:0] feistel(input logic [31:0] rh, input logic [47:0] sk);
    logic [47:0] x;
    logic [31:0] sv;
    logic [31:0] r;
    logic [5:0]  six;
    int          idx;
    int          v;
    x  = '0;
    sv = '0;
    r  = '0;
    for (int i = 0; i < 48; i++) x[47-i] = rh[32-E_T[i]];
    x = x ^ sk;
    for (int b = 0; b < 8; b++) begin
      six = x[47-6*b -: 6];
      idx = b*64 + int'({six[5], six[0]})*16 + int'(six[4:1]);
      v   = SBOX_T[idx];
      sv[31-4*b -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) r[31-i] = sv[32-P_T[i]];
    return r;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] x, input logic left, input logic [1:0] n);
    logic [27:0] r;
    r = x;
    case ({left, n})
      3'b101:  r = {x[26:0], x[27]};
      3'b110:  r = {x[25:0], x[27:26]};
      3'b001:  r = {x[0], x[27:1]};
      3'b010:  r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] kc_q, kc_d, kd_q, kd_d;
  logic        enc_q, enc_d;
  logic [63:0] out_q, out_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [1:0]  shift_n;
  logic [27:0] kc_rot, kd_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;
  logic [63:0] ip_in;
  logic [55:0] cd0;

  // Per-round key rotation and round function; decrypt walks the schedule backwards.
  always_comb begin
    shift_n = 2'd2;
    if (enc_q) begin
      if (cnt_q == 5'd1 || cnt_q == 5'd2 || cnt_q == 5'd9 || cnt_q == 5'd16) shift_n = 2'd1;
    end else begin
      if (cnt_q == 5'd1) shift_n = 2'd0;
      else if (cnt_q == 5'd2 || cnt_q == 5'd9 || cnt_q == 5'd16) shift_n = 2'd1;
    end
    kc_rot = rot28(kc_q, enc_q, shift_n);
    kd_rot = rot28(kd_q, enc_q, shift_n);
    subkey = pc2_perm({kc_rot, kd_rot});
    f_out  = feistel(r_q, subkey);
    ip_in  = ip_perm(in);
    cd0    = pc1_perm(k);
  end

  // Next-state: capture on start, run 16 rounds, then publish the swapped, final-permuted block.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    kc_d    = kc_q;
    kd_d    = kd_q;
    enc_d   = enc_q;
    out_d   = out_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_ROUND: begin
        l_d   = r_q;
        r_d   = l_q ^ f_out;
        kc_d  = kc_rot;
        kd_d  = kd_rot;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd16) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        out_d   = fp_perm({r_q, l_q});
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = 5'd0;
        state_d = ST_IDLE;
      end
      default: ;
    endcase
    // The final edge counts as idle so back-to-back starts keep a 17-cycle period.
    if (s && (state_q == ST_IDLE || state_q == ST_FINAL)) begin
      {l_d, r_d}   = ip_in;
      {kc_d, kd_d} = cd0;
      enc_d        = e;
      cnt_d        = 5'd1;
      busy_d       = 1'b1;
      state_d      = ST_ROUND;
    end
  end

  // State registers with asynchronous clear; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      kc_q    <= '0;
      kd_q    <= '0;
      enc_q   <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      kc_q    <= kc_d;
      kd_q    <= kd_d;
      enc_q   <= enc_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_des_core.sv
module tb_des_core;

  logic        clk;
  logic        rst;
  logic        s_i;
  logic        e_i;
  logic [55:0] k_i;
  logic [63:0] in_i;
  logic [63:0] out_o;
  logic        done_o;
  logic        busy_o;

  des_core dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s_i),
    .e    (e_i),
    .k    (k_i),
    .in   (in_i),
    .out  (out_o),
    .done (done_o),
    .busy (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [55:0] KEY1 = 56'h12695BC9B7B7F8;
  localparam logic [55:0] KEY2 = 56'h0E66499EAD8339;

  typedef struct {
    logic [63:0] dat;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          n_cmp;
  int          n_err;
  int          n_done;
  logic [63:0] out_prev;

  // Known-answer vector table: key, mode, input, expected result.
  logic [55:0] vk [4];
  logic        ve [4];
  logic [63:0] vi [4];
  logic [63:0] vo [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse is matched against the oldest expected result and its due edge.
  always @(negedge clk) begin
    if (!rst && done_o) begin
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("result", out_o, x.dat);
        check("latency", 64'(cyc), 64'(x.cyc));
      end
    end
    if (!rst && !done_o && out_o !== out_prev) check("out_stable", out_o, out_prev);
    out_prev <= out_o;
  end

  // Drive one start at the current negedge; result due 17 edges after the sampling edge.
  task automatic drive_op(input logic [55:0] kk, input logic ee, input logic [63:0] din,
                          input logic [63:0] dexp);
    exp_t x;
    k_i  = kk;
    e_i  = ee;
    in_i = din;
    s_i  = 1'b1;
    x.dat = dexp;
    x.cyc = cyc + 18;
    sb.push_back(x);
    @(negedge clk);
    s_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int unsigned t0;
    int          d0;
    logic [63:0] rnd;
    cyc = 0; n_cmp = 0; n_err = 0; n_done = 0; out_prev = '0;
    vk[0] = KEY1; ve[0] = 1'b1; vi[0] = 64'h0123456789ABCDEF; vo[0] = 64'h85E813540F0AB405;
    vk[1] = KEY1; ve[1] = 1'b0; vi[1] = 64'h85E813540F0AB405; vo[1] = 64'h0123456789ABCDEF;
    vk[2] = KEY2; ve[2] = 1'b1; vi[2] = 64'h8787878787878787; vo[2] = 64'h0000000000000000;
    vk[3] = KEY2; ve[3] = 1'b0; vi[3] = 64'h0000000000000000; vo[3] = 64'h8787878787878787;
    rst = 1'b1; s_i = 1'b0; e_i = 1'b0; k_i = '0; in_i = '0;
    repeat (3) @(negedge clk);
    check("rst_out", out_o, 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single operations over the known-answer table, with busy checked around each.
    for (int v = 0; v < 4; v++) begin
      drive_op(vk[v], ve[v], vi[v], vo[v]);
      check("busy_running", 64'(busy_o), 64'd1);
      wait_idle();
      check("busy_after", 64'(busy_o), 64'd0);
    end

    // Start held high, inputs churning every cycle; only the values on accepted edges matter.
    for (int j = 0; j < 68; j++) begin
      if (j % 17 == 0) begin
        exp_t x;
        k_i  = vk[j/17];
        e_i  = ve[j/17];
        in_i = vi[j/17];
        x.dat = vo[j/17];
        x.cyc = cyc + 18;
        sb.push_back(x);
      end else begin
        rnd  = {$urandom, $urandom};
        k_i  = rnd[55:0];
        in_i = {$urandom, $urandom};
        e_i  = rnd[56];
      end
      s_i = 1'b1;
      @(negedge clk);
    end
    s_i = 1'b0;
    wait_idle();

    // Reset during round 8 aborts silently; out is cleared.
    drive_op(KEY1, 1'b1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    t0 = cyc;
    while (cyc < t0 + 8) @(negedge clk);
    check("busy_mid", 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    check("abort_out", out_o, 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_done", 64'(done_o), 64'd0);
    d0 = n_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("no_done_after_abort", 64'(n_done), 64'(d0));
    drive_op(KEY1, 1'b1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
    wait_idle();

    // Start sampled on the done edge: second result 17 edges after the first.
    drive_op(KEY2, 1'b1, 64'h8787878787878787, 64'h0000000000000000);
    t0 = cyc;
    while (cyc < t0 + 16) @(negedge clk);
    drive_op(KEY1, 1'b0, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
